// File: rtl/idli_sqi_burst_m.sv
// SQI burst controller for NUM_MEM nibble-wide SQI SRAMs sharing SCK and CS.
// Each memory carries one 4-bit lane of a 4*NUM_MEM-bit word. CMD and ADDR nibbles
// are broadcast on every lane. Sequential same-direction requests extend the burst.
// SCK = gck/2; each SCK period is an L phase (sck=0) followed by an H phase (sck=1).
// Optional feature macro: IDLI_SQI_HOLD_EN (lets a burst pause up to HOLD_MAX gck).
//
// Ports:
//   i_sqi_gck, i_sqi_rst        core clock, asynchronous active-high reset
//   i_sqi_req_vld/o_sqi_req_rdy request handshake (wr, addr, data held until accepted)
//   i_sqi_req_wr/addr/data      request fields
//   o_sqi_rsp_vld/o_sqi_rsp_data one-cycle read-data pulse, no backpressure
//   o_sqi_busy                  controller not idle
//   o_sqi_sck, o_sqi_cs         shared SCK and active-low CS, both straight from flops
//   o_sqi_oe, o_sqi_sio         SIO output enable and per-lane output nibbles
//   i_sqi_sio                   per-lane input nibbles
module idli_sqi_burst_m #(
  parameter int NUM_MEM   = 4,
  parameter int ADDR_W    = 16,
  parameter int DUMMY_CYC = 1
`ifdef IDLI_SQI_HOLD_EN
  , parameter int HOLD_MAX = 8
`endif
) (
  input  logic                   i_sqi_gck,
  input  logic                   i_sqi_rst,
  input  logic                   i_sqi_req_vld,
  output logic                   o_sqi_req_rdy,
  input  logic                   i_sqi_req_wr,
  input  logic [ADDR_W-1:0]      i_sqi_req_addr,
  input  logic [4*NUM_MEM-1:0]   i_sqi_req_data,
  output logic                   o_sqi_rsp_vld,
  output logic [4*NUM_MEM-1:0]   o_sqi_rsp_data,
  output logic                   o_sqi_busy,
  output logic                   o_sqi_sck,
  output logic                   o_sqi_cs,
  output logic                   o_sqi_oe,
  output logic [NUM_MEM*4-1:0]   o_sqi_sio,
  input  logic [NUM_MEM*4-1:0]   i_sqi_sio
);

  localparam int W       = 4 * NUM_MEM;
  localparam int N_ADDR  = ADDR_W / 4;
  localparam int CNT_MAX = (N_ADDR > DUMMY_CYC) ? N_ADDR : DUMMY_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
`ifdef IDLI_SQI_HOLD_EN
  localparam int HC_W    = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
`endif

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic       PH_L      = 1'b0;
  localparam logic       PH_H      = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_CS_HI
`ifdef IDLI_SQI_HOLD_EN
    , S_HOLD
`endif
  } state_t;

  state_t              state_q, state_d;
  logic                ph_q, ph_d;        // current SCK phase
  logic                lead_q, lead_d;    // one gck lead-in between accept and CMD
  logic [CNT_W-1:0]    cnt_q, cnt_d;      // SCK index within CMD/ADDR/DUMMY
  logic [ADDR_W-1:0]   sh_q, sh_d;        // address nibbles still to be sent
  logic                sck_q, sck_d;
  logic                cs_q, cs_d;
  logic                oe_q, oe_d;
  logic [W-1:0]        sio_q, sio_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic [W-1:0]        rsp_data_q, rsp_data_d;
  logic                wr_q, wr_d;        // direction of the burst in flight
  logic [ADDR_W-1:0]   addr_q, addr_d;    // address of the word in flight
  logic [W-1:0]        wdata_q, wdata_d;
`ifdef IDLI_SQI_HOLD_EN
  logic [HC_W-1:0]     hold_q, hold_d;
`endif

  logic [ADDR_W-1:0]   next_addr;
  logic                match;
  logic                rdy;
  logic                accept;
  logic [7:0]          cmd_byte;

  function automatic logic [W-1:0] bcast(input logic [3:0] nib);
    return {NUM_MEM{nib}};
  endfunction

  assign cmd_byte = wr_q ? CMD_WRITE : CMD_READ;

  // A request may join the running burst only if it is the next word in the same direction.
  always_comb begin
    next_addr = addr_q + ADDR_W'(1);
    match     = i_sqi_req_vld && (i_sqi_req_wr == wr_q) && (i_sqi_req_addr == next_addr);
    case (state_q)
      S_IDLE:  rdy = 1'b1;
      S_DATA:  rdy = (ph_q == PH_H) && match;
`ifdef IDLI_SQI_HOLD_EN
      S_HOLD:  rdy = match;
`endif
      default: rdy = 1'b0;
    endcase
  end

  assign accept = i_sqi_req_vld && rdy;

  always_ff @(posedge i_sqi_gck or posedge i_sqi_rst) begin
    if (i_sqi_rst) begin
      state_q    <= S_IDLE;
      ph_q       <= PH_L;
      lead_q     <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      oe_q       <= 1'b0;
      sio_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef IDLI_SQI_HOLD_EN
      hold_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      lead_q     <= lead_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      oe_q       <= oe_d;
      sio_q      <= sio_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef IDLI_SQI_HOLD_EN
      hold_q     <= hold_d;
`endif
    end
  end

  // Every H phase ends on an edge that enters the L phase of the next SCK slot;
  // all SIO/oe/state changes happen on that edge so the memory sees stable data
  // at the following rising SCK edge.
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    lead_d     = lead_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    oe_d       = oe_q;
    sio_d      = sio_q;
    rsp_vld_d  = 1'b0;
    rsp_data_d = rsp_data_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef IDLI_SQI_HOLD_EN
    hold_d     = hold_q;
`endif

    case (state_q)
      S_IDLE: begin
        sck_d = 1'b0;
        if (accept) begin
          // Park in a pseudo H phase so the next edge starts CMD slot 0 with CS low.
          state_d = S_CMD;
          ph_d    = PH_H;
          lead_d  = 1'b1;
          wr_d    = i_sqi_req_wr;
          addr_d  = i_sqi_req_addr;
          wdata_d = i_sqi_req_data;
        end
      end

      S_CMD: begin
        if (ph_q == PH_L) begin
          ph_d  = PH_H;
          sck_d = 1'b1;
        end else begin
          ph_d  = PH_L;
          sck_d = 1'b0;
          if (lead_q) begin
            lead_d = 1'b0;
            cs_d   = 1'b0;
            oe_d   = 1'b1;
            cnt_d  = '0;
            sio_d  = bcast(cmd_byte[7:4]);
          end else if (cnt_q == '0) begin
            cnt_d = CNT_W'(1);
            sio_d = bcast(cmd_byte[3:0]);
          end else begin
            state_d = S_ADDR;
            cnt_d   = '0;
            sio_d   = bcast(addr_q[ADDR_W-1 -: 4]);
            sh_d    = addr_q << 4;
          end
        end
      end

      S_ADDR: begin
        if (ph_q == PH_L) begin
          ph_d  = PH_H;
          sck_d = 1'b1;
        end else begin
          ph_d  = PH_L;
          sck_d = 1'b0;
          if (cnt_q != CNT_W'(N_ADDR - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
            sio_d = bcast(sh_q[ADDR_W-1 -: 4]);
            sh_d  = sh_q << 4;
          end else begin
            cnt_d = '0;
            if (wr_q) begin
              // Writes go straight to data; the memory needs no turnaround.
              state_d = S_DATA;
              oe_d    = 1'b1;
              sio_d   = wdata_q;
            end else if (DUMMY_CYC > 0) begin
              state_d = S_DUMMY;
              oe_d    = 1'b0;
              sio_d   = '0;
            end else begin
              state_d = S_DATA;
              oe_d    = 1'b0;
              sio_d   = '0;
            end
          end
        end
      end

      S_DUMMY: begin
        if (ph_q == PH_L) begin
          ph_d  = PH_H;
          sck_d = 1'b1;
        end else begin
          ph_d  = PH_L;
          sck_d = 1'b0;
          if (cnt_q != CNT_W'(DUMMY_CYC - 1)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d   = '0;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (ph_q == PH_L) begin
          ph_d  = PH_H;
          sck_d = 1'b1;
        end else begin
          ph_d  = PH_L;
          sck_d = 1'b0;
          // Read data is valid for the whole H phase; capture it as H closes.
          if (!wr_q) begin
            rsp_vld_d  = 1'b1;
            rsp_data_d = i_sqi_sio;
          end
          if (accept) begin
            addr_d  = i_sqi_req_addr;
            wdata_d = i_sqi_req_data;
            if (wr_q) begin
              sio_d = i_sqi_req_data;
            end
`ifdef IDLI_SQI_HOLD_EN
          end else if (!i_sqi_req_vld) begin
            state_d = S_HOLD;
            hold_d  = '0;
`endif
          end else begin
            state_d = S_CS_HI;
            cs_d    = 1'b1;
            oe_d    = 1'b0;
            sio_d   = '0;
          end
        end
      end

`ifdef IDLI_SQI_HOLD_EN
      // SCK parked low with CS still asserted; the memory simply waits.
      S_HOLD: begin
        sck_d = 1'b0;
        if (accept) begin
          state_d = S_DATA;
          ph_d    = PH_L;
          addr_d  = i_sqi_req_addr;
          wdata_d = i_sqi_req_data;
          if (wr_q) begin
            sio_d = i_sqi_req_data;
          end
        end else if (i_sqi_req_vld || (hold_q == HC_W'(HOLD_MAX - 1))) begin
          state_d = S_CS_HI;
          ph_d    = PH_L;
          cs_d    = 1'b1;
          oe_d    = 1'b0;
          sio_d   = '0;
        end else begin
          hold_d = hold_q + HC_W'(1);
        end
      end
`endif

      // One SCK period of CS-high time; SCK stays low since no memory is selected.
      S_CS_HI: begin
        sck_d = 1'b0;
        if (ph_q == PH_L) begin
          ph_d = PH_H;
        end else begin
          ph_d    = PH_L;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        ph_d    = PH_L;
        lead_d  = 1'b0;
        sck_d   = 1'b0;
        cs_d    = 1'b1;
        oe_d    = 1'b0;
        sio_d   = '0;
      end
    endcase
  end

  assign o_sqi_req_rdy  = rdy;
  assign o_sqi_rsp_vld  = rsp_vld_q;
  assign o_sqi_rsp_data = rsp_data_q;
  assign o_sqi_busy     = (state_q != S_IDLE);
  assign o_sqi_sck      = sck_q;
  assign o_sqi_cs       = cs_q;
  assign o_sqi_oe       = oe_q;
  assign o_sqi_sio      = sio_q;

endmodule

// File: tb/tb_idli_sqi_burst_m.sv
// Bench for idli_sqi_burst_m with default parameters (4 lanes, 16-bit address, 1 dummy).
// A behavioural SQI memory answers on the bus; expected read words and expected CMD/ADDR
// headers are queued at stimulus time and popped by independent monitors.
module tb_idli_sqi_burst_m;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          vld = 1'b0;
  logic          wr  = 1'b0;
  logic [15:0]   addr = '0;
  logic [W-1:0]  data = '0;
  logic          rdy, rsp_vld, busy, sck, cs, oe;
  logic [W-1:0]  rsp_data, sio_o, sio_i;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  idli_sqi_burst_m dut (
    .i_sqi_gck      (clk),
    .i_sqi_rst      (rst),
    .i_sqi_req_vld  (vld),
    .o_sqi_req_rdy  (rdy),
    .i_sqi_req_wr   (wr),
    .i_sqi_req_addr (addr),
    .i_sqi_req_data (data),
    .o_sqi_rsp_vld  (rsp_vld),
    .o_sqi_rsp_data (rsp_data),
    .o_sqi_busy     (busy),
    .o_sqi_sck      (sck),
    .o_sqi_cs       (cs),
    .o_sqi_oe       (oe),
    .o_sqi_sio      (sio_o),
    .i_sqi_sio      (sio_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- memory model (all lanes share one header) ----------------
  logic [W-1:0] mem [0:65535];
  logic [7:0]   m_cmd  = '0;
  logic [15:0]  m_addr = '0;
  int           m_n    = 0;
  int           m_wr_words = 0;
  int           cs_win = 0;
  logic [23:0]  txn_q[$];

  always @(posedge sck or posedge cs) begin
    if (cs === 1'b1) begin
      m_n <= 0;
    end else begin
      if (m_n < 6) begin
        check("hdr_bus_oe_lanes", {31'b0, oe && (sio_o == {4{sio_o[3:0]}})}, 32'd1);
      end
      if (m_n < 2) begin
        m_cmd <= {m_cmd[3:0], sio_o[3:0]};
      end else if (m_n < 6) begin
        m_addr <= {m_addr[11:0], sio_o[3:0]};
        if (m_n == 5) begin
          if (txn_q.size() == 0) fail_now("txn_unexpected");
          else check("txn_cmd_addr", {8'h0, m_cmd, m_addr[11:0], sio_o[3:0]},
                     {8'h0, txn_q.pop_front()});
        end
      end else if (m_cmd == 8'h02) begin
        mem[m_addr + 16'(m_n - 6)] <= sio_o;
        m_wr_words <= m_wr_words + 1;
      end
      m_n <= m_n + 1;
    end
  end

  always @(negedge cs) cs_win++;

  // Read word j of the burst is presented once the rising edge of its DATA slot has passed.
  assign sio_i = (cs === 1'b0 && m_cmd == 8'h03 && m_n >= 8) ? mem[m_addr + 16'(m_n - 8)] : 16'h0;

  // ---------------- response scoreboard ----------------
  typedef struct {
    logic [W-1:0] data;
    int           lat;
    time          t_acc;
  } rsp_exp_t;
  rsp_exp_t rsp_q[$];

  always @(negedge clk) begin
    if (rsp_vld === 1'b1) begin
      if (rsp_q.size() == 0) begin
        fail_now("rsp_unexpected");
      end else begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        check("rsp_data", {16'h0, rsp_data}, {16'h0, e.data});
        if (e.lat > 0) check("rsp_latency", int'(($time - 5 - e.t_acc) / 10), e.lat);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic w, input logic [15:0] a, input logic [W-1:0] d,
                       input int lat, input logic [W-1:0] exp_rd, output time t);
    bit done;
    done = 1'b0;
    t = 0;
    @(negedge clk);
    vld = 1'b1; wr = w; addr = a; data = d;
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (rdy === 1'b1) begin
        @(posedge clk);
        t = $time;
        done = 1'b1;
        if (!w) begin
          rsp_exp_t e;
          e.data = exp_rd; e.lat = lat; e.t_acc = $time;
          rsp_q.push_back(e);
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      fail_now("accept_timeout");
      vld = 1'b0;
    end
  endtask

  task automatic drop_req();
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      if (busy === 1'b0) idle = 1'b1;
    end
    if (!idle) fail_now("idle_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    time ta, tb, tx;
    int w0, k0;

    // ---- reset ----
    #1 rst = 1'b1;
    #11;
    check("rst_cs", {31'b0, cs}, 32'd1);
    check("rst_sck", {31'b0, sck}, 32'd0);
    check("rst_oe", {31'b0, oe}, 32'd0);
    check("rst_sio", {16'h0, sio_o}, 32'h0);
    check("rst_rsp_vld", {31'b0, rsp_vld}, 32'd0);
    check("rst_rsp_data", {16'h0, rsp_data}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    #1 check("idle_rdy", {31'b0, rdy}, 32'd1);

    // ---- single read 0x1234 -> 0xBEEF, 17 gck latency, CS_HI 2 gck, then rdy ----
    mem[16'h1234] = 16'hBEEF;
    txn_q.push_back({8'h03, 16'h1234});
    issue(1'b0, 16'h1234, 16'h0, 17, 16'hBEEF, ta);
    drop_req();
    repeat (16) @(negedge clk);
    #1 check("cs_low_last_word", {31'b0, cs}, 32'd0);
    @(negedge clk);
    #1 check("cs_hi_entry", {31'b0, cs}, 32'd1);
    check("rdy_cs_hi_l", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    #1 check("rdy_cs_hi_h", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    #1 check("rdy_after_cs_hi", {31'b0, rdy}, 32'd1);
    check("busy_after_cs_hi", {31'b0, busy}, 32'd0);

    // ---- write burst 0x0010..0x0013 in one CS window ----
    w0 = cs_win; k0 = m_wr_words;
    txn_q.push_back({8'h02, 16'h0010});
    for (int i = 0; i < 4; i++) issue(1'b1, 16'h0010 + 16'(i), 16'hA001 + 16'(i), 0, 16'h0, tx);
    drop_req();
    wait_idle();
    for (int i = 0; i < 4; i++) check("wr_burst_mem", {16'h0, mem[16'h0010 + 16'(i)]}, {16'h0, 16'hA001 + 16'(i)});
    check("wr_burst_cs_windows", cs_win - w0, 32'd1);
    check("wr_burst_data_sck", m_wr_words - k0, 32'd4);

    // ---- non-sequential reads: second waits for IDLE, two full headers ----
    mem[16'h0020] = 16'h2020;
    mem[16'h0040] = 16'h4040;
    w0 = cs_win;
    txn_q.push_back({8'h03, 16'h0020});
    txn_q.push_back({8'h03, 16'h0040});
    issue(1'b0, 16'h0020, 16'h0, 17, 16'h2020, ta);
    issue(1'b0, 16'h0040, 16'h0, 17, 16'h4040, tb);
    drop_req();
    wait_idle();
    check("nonseq_accept_gap", int'((tb - ta) / 10), 32'd20);
    check("nonseq_cs_windows", cs_win - w0, 32'd2);

    // ---- address wrap 0xFFFF -> 0x0000 stays in one burst ----
    mem[16'hFFFF] = 16'hCAFE;
    mem[16'h0000] = 16'h0BAD;
    w0 = cs_win;
    txn_q.push_back({8'h03, 16'hFFFF});
    issue(1'b0, 16'hFFFF, 16'h0, 17, 16'hCAFE, ta);
    issue(1'b0, 16'h0000, 16'h0, 2, 16'h0BAD, tb);
    drop_req();
    wait_idle();
    check("wrap_cs_windows", cs_win - w0, 32'd1);

    // ---- reset during ADDR of a write, then a clean restart ----
    mem[16'h0300] = 16'h0000;
    issue(1'b1, 16'h0300, 16'h1234, 0, 16'h0, tx);
    drop_req();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cs", {31'b0, cs}, 32'd1);
    check("midrst_sck", {31'b0, sck}, 32'd0);
    check("midrst_oe", {31'b0, oe}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk); rst = 1'b0;
    txn_q.push_back({8'h02, 16'h0300});
    issue(1'b1, 16'h0300, 16'h5678, 0, 16'h0, tx);
    drop_req();
    wait_idle();
    check("restart_wr_mem", {16'h0, mem[16'h0300]}, 32'h5678);

    repeat (4) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 32'd0);
    check("txn_queue_drained", txn_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
